// File: rtl/pet_pkg.sv
// rtl/pet_pkg.sv - shared mood state codes, default thresholds and stat helpers
package pet_pkg;

    // Mood state codes; the display block decodes these same values
    typedef enum logic [2:0] {
        ST_HAPPY = 3'd0,
        ST_NEEDY = 3'd1,
        ST_SICK  = 3'd2,
        ST_SLEEP = 3'd3,
        ST_DEAD  = 3'd4
    } pet_state_e;

    // Default behaviour constants (27 MHz clock, one evaluation per second)
    localparam int DEF_TICK_DIV    = 27_000_000;
    localparam int DEF_SICK_TH     = 12;
    localparam int DEF_NEEDY_TH    = 8;
    localparam int DEF_CRIT_TICKS  = 10;
    localparam int DEF_SLEEP_TICKS = 8;

    // Stat levels are 4-bit need levels, 0 best and 15 worst
    localparam logic [3:0] STAT_WORST = 4'hF;

    // Larger of two need levels
    function automatic logic [3:0] stat_max(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? a : b;
    endfunction

    // Zero-extend a need level to the care_score width
    function automatic logic [6:0] stat_ext(input logic [3:0] a);
        return {3'b000, a};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - evaluation tick prescaler with one-cycle registered strobe
module tick_gen #(
    parameter int TICK_DIV = 27_000_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int          CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;
    logic             at_term;

    assign at_term = (cnt_q == TERM);

    // Count 0..TICK_DIV-1 and wrap; strobe is registered so it lands TICK_DIV cycles after reset release
    always_comb begin
        cnt_d  = at_term ? '0 : cnt_q + 1'b1;
        tick_d = at_term;
    end

    // Prescaler state; reset restarts the full period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/pet_mood.sv
// rtl/pet_mood.sv - virtual pet mood FSM with alarm, death latch and care score
module pet_mood
    import pet_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int SICK_TH     = DEF_SICK_TH,
    parameter int NEEDY_TH    = DEF_NEEDY_TH,
    parameter int CRIT_TICKS  = DEF_CRIT_TICKS,
    parameter int SLEEP_TICKS = DEF_SLEEP_TICKS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] hunger,
    input  logic [3:0] happiness,
    input  logic [3:0] health,
    input  logic [3:0] hygiene,
    input  logic [3:0] energy,
    input  logic [3:0] social,
    input  logic       wake,
    output logic [2:0] mood,
    output logic       alarm,
    output logic       dead,
    output logic [6:0] care_score,
    output logic       tick
);

    localparam int CRIT_W  = (CRIT_TICKS  > 0) ? $clog2(CRIT_TICKS + 1)  : 1;
    localparam int SLEEP_W = (SLEEP_TICKS > 0) ? $clog2(SLEEP_TICKS + 1) : 1;

    localparam logic [CRIT_W-1:0]  CRIT_MAX  = CRIT_W'(CRIT_TICKS);
    localparam logic [SLEEP_W-1:0] SLEEP_MAX = SLEEP_W'(SLEEP_TICKS);
    localparam logic [3:0]         SICK_LVL  = 4'(SICK_TH);
    localparam logic [3:0]         NEEDY_LVL = 4'(NEEDY_TH);

    logic               tick_w;
    logic               wake_q, wake_d, wake_p;
    pet_state_e         state_q, state_d;
    pet_state_e         awake_next;
    logic [CRIT_W-1:0]  crit_q, crit_d, crit_inc;
    logic [SLEEP_W-1:0] sleep_q, sleep_d, sleep_inc;
    logic               alarm_q, alarm_d;
    logic               dead_q, dead_d;
    logic [6:0]         care_q, care_d;
    logic [3:0]         worst;
    logic [6:0]         stat_sum;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick_w)
    );

    // Rising edge of the debounced button; a held level yields a single pulse
    assign wake_d = wake;
    assign wake_p = wake & ~wake_q;

    // Worst need level and total need across all six stats (max 90 fits in 7 bits)
    always_comb begin
        worst    = stat_max(stat_max(stat_max(hunger, happiness), stat_max(health, hygiene)),
                            stat_max(energy, social));
        stat_sum = stat_ext(hunger) + stat_ext(happiness) + stat_ext(health)
                 + stat_ext(hygiene) + stat_ext(energy) + stat_ext(social);
    end

    // Saturating increments so the counters park at their limits instead of wrapping
    always_comb begin
        crit_inc  = (crit_q  < CRIT_MAX)  ? crit_q  + 1'b1 : crit_q;
        sleep_inc = (sleep_q < SLEEP_MAX) ? sleep_q + 1'b1 : sleep_q;
    end

    // Destination from HAPPY/NEEDY: sickness beats tiredness beats general neediness
    always_comb begin
        if (health >= SICK_LVL) begin
            awake_next = ST_SICK;
        end else if (energy >= SICK_LVL) begin
            awake_next = ST_SLEEP;
        end else if (worst >= NEEDY_LVL) begin
            awake_next = ST_NEEDY;
        end else begin
            awake_next = ST_HAPPY;
        end
    end

    // Next state and counter updates; counters are cleared whenever their state is left
    always_comb begin
        state_d = state_q;
        crit_d  = crit_q;
        sleep_d = sleep_q;
        case (state_q)
            ST_HAPPY, ST_NEEDY: begin
                if (tick_w) begin
                    state_d = awake_next;
                end
            end
            ST_SICK: begin
                if (tick_w) begin
                    crit_d = (health == STAT_WORST) ? crit_inc : '0;
                    if (crit_d == CRIT_MAX) begin
                        state_d = ST_DEAD;
                    end else if (health < SICK_LVL) begin
                        state_d = ST_NEEDY;
                    end
                end
            end
            ST_SLEEP: begin
                if (tick_w) begin
                    sleep_d = sleep_inc;
                    if (health >= SICK_LVL) begin
                        state_d = ST_SICK;
                    end else if (sleep_d == SLEEP_MAX) begin
                        state_d = ST_NEEDY;
                    end
                end
                // A button press wakes the pet unless the same tick just made it sick
                if (wake_p && (state_d != ST_SICK)) begin
                    state_d = ST_NEEDY;
                end
            end
            ST_DEAD: begin
                state_d = ST_DEAD;
            end
            default: begin
                state_d = ST_HAPPY;
            end
        endcase
        if (state_d != ST_SICK) begin
            crit_d = '0;
        end
        if (state_d != ST_SLEEP) begin
            sleep_d = '0;
        end
    end

    // Outputs are computed from the next state so they line up with mood
    always_comb begin
        alarm_d = (state_d == ST_SICK) || ((state_d == ST_NEEDY) && (worst == STAT_WORST));
        dead_d  = (state_d == ST_DEAD);
        care_d  = tick_w ? stat_sum : care_q;
    end

    // State, counters, edge detector and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_HAPPY;
            crit_q  <= '0;
            sleep_q <= '0;
            wake_q  <= 1'b0;
            alarm_q <= 1'b0;
            dead_q  <= 1'b0;
            care_q  <= '0;
        end else begin
            state_q <= state_d;
            crit_q  <= crit_d;
            sleep_q <= sleep_d;
            wake_q  <= wake_d;
            alarm_q <= alarm_d;
            dead_q  <= dead_d;
            care_q  <= care_d;
        end
    end

    assign mood       = state_q;
    assign alarm      = alarm_q;
    assign dead       = dead_q;
    assign care_score = care_q;
    assign tick       = tick_w;

endmodule

// File: tb/tb_pet_mood.sv
// tb/tb_pet_mood.sv - self-checking bench for pet_mood with TICK_DIV=4
module tb_pet_mood;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] hunger, happiness, health, hygiene, energy, social;
    logic       wake;
    logic [2:0] mood;
    logic       alarm, dead, tick;
    logic [6:0] care_score;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int tick_cyc  = 0;
    int prev_tick = 0;
    int rel_cyc   = 0;

    typedef struct {
        logic [3:0] hu, ha, he, hy, en, so;
        int         mood;
        int         alarm;
        int         dead;
        int         care;
    } vec_t;

    typedef struct {
        int mood;
        int alarm;
        int dead;
        int care;
    } exp_t;

    vec_t tbl [10];
    exp_t sb [$];

    pet_mood #(
        .TICK_DIV    (4),
        .SICK_TH     (12),
        .NEEDY_TH    (8),
        .CRIT_TICKS  (10),
        .SLEEP_TICKS (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hunger     (hunger),
        .happiness  (happiness),
        .health     (health),
        .hygiene    (hygiene),
        .energy     (energy),
        .social     (social),
        .wake       (wake),
        .mood       (mood),
        .alarm      (alarm),
        .dead       (dead),
        .care_score (care_score),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure tick spacing
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int m, input int a, input int d, input int c);
        exp_t e;
        e.mood = m; e.alarm = a; e.dead = d; e.care = c;
        sb.push_back(e);
    endtask

    task automatic check_out(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            cmp({name, ".scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            cmp({name, ".mood"},  int'(mood),       e.mood);
            cmp({name, ".alarm"}, int'(alarm),      e.alarm);
            cmp({name, ".dead"},  int'(dead),       e.dead);
            cmp({name, ".care"},  int'(care_score), e.care);
        end
    endtask

    task automatic set_stats(input logic [3:0] hu, ha, he, hy, en, so);
        hunger = hu; happiness = ha; health = he; hygiene = hy; energy = en; social = so;
    endtask

    function automatic int stat_sum();
        return int'(hunger) + int'(happiness) + int'(health) + int'(hygiene) + int'(energy) + int'(social);
    endfunction

    // Find the tick-high cycle, let the DUT consume it, sample at the following negedge
    task automatic wait_tick(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 20);
        if (!tick) cmp({name, ".tick_timeout"}, 0, 1);
        prev_tick = tick_cyc;
        tick_cyc  = cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{4'd0, 4'd0, 4'd0,  4'd0,  4'd0,  4'd0,  0, 0, 0, 0};
        tbl[1] = '{4'd0, 4'd0, 4'd0,  4'd0,  4'd0,  4'd0,  0, 0, 0, 0};
        tbl[2] = '{4'd0, 4'd0, 4'd0,  4'd0,  4'd0,  4'd0,  0, 0, 0, 0};
        tbl[3] = '{4'd0, 4'd0, 4'd0,  4'd15, 4'd0,  4'd0,  1, 1, 0, 15};
        tbl[4] = '{4'd3, 4'd0, 4'd0,  4'd9,  4'd0,  4'd0,  1, 0, 0, 12};
        tbl[5] = '{4'd7, 4'd0, 4'd0,  4'd0,  4'd0,  4'd0,  0, 0, 0, 7};
        tbl[6] = '{4'd15,4'd15,4'd15, 4'd15, 4'd15, 4'd15, 2, 1, 0, 90};
        tbl[7] = '{4'd0, 4'd0, 4'd12, 4'd0,  4'd0,  4'd0,  2, 1, 0, 12};
        tbl[8] = '{4'd0, 4'd0, 4'd11, 4'd0,  4'd0,  4'd0,  1, 0, 0, 11};
        tbl[9] = '{4'd0, 4'd0, 4'd0,  4'd0,  4'd12, 4'd0,  3, 0, 0, 12};

        reset_n = 1'b0;
        wake    = 1'b0;
        set_stats(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        push(0, 0, 0, 0);
        check_out("reset");
        cmp("reset.tick", int'(tick), 0);
        reset_n = 1'b1;
        rel_cyc = cyc;

        // Table: one vector per tick, starting right after reset
        for (int i = 0; i < 10; i++) begin
            set_stats(tbl[i].hu, tbl[i].ha, tbl[i].he, tbl[i].hy, tbl[i].en, tbl[i].so);
            push(tbl[i].mood, tbl[i].alarm, tbl[i].dead, tbl[i].care);
            wait_tick($sformatf("tbl%0d", i));
            if (i == 0) cmp("first_tick_after_reset", tick_cyc - rel_cyc, 4);
            else        cmp($sformatf("tbl%0d.tick_spacing", i), tick_cyc - prev_tick, 4);
            check_out($sformatf("tbl%0d", i));
        end

        // Wake mid-period from SLEEP goes to NEEDY on the next clock
        energy = 4'd0;
        wake   = 1'b1;
        push(1, 0, 0, 12);
        @(posedge clk);
        @(negedge clk);
        check_out("wake_mid");

        // Re-enter SLEEP with wake still held: no second wake effect
        energy = 4'd13;
        push(3, 0, 0, 13);
        wait_tick("sleep_enter");
        check_out("sleep_enter");
        energy = 4'd0;
        repeat (2) @(negedge clk);
        push(3, 0, 0, 13);
        check_out("wake_held");

        // Auto-wake after eight ticks asleep
        for (int i = 1; i <= 8; i++) begin
            push((i == 8) ? 1 : 3, 0, 0, 0);
            wait_tick($sformatf("sleep_t%0d", i));
            check_out($sformatf("sleep_t%0d", i));
        end
        wake = 1'b0;

        // Wake and tick in the same cycle while health crosses the sick threshold
        energy = 4'd13;
        push(3, 0, 0, 13);
        wait_tick("sleep2_enter");
        check_out("sleep2_enter");
        energy = 4'd0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!tick && n < 20);
            if (!tick) cmp("same_cycle.tick_timeout", 0, 1);
        end
        wake   = 1'b1;
        health = 4'd12;
        push(2, 1, 0, stat_sum());
        @(posedge clk);
        @(negedge clk);
        check_out("wake_tick_sick");
        wake = 1'b0;

        // Build crit_cnt to 5 in SICK, then pulse reset for one cycle
        health = 4'd15;
        for (int i = 1; i <= 5; i++) begin
            push(2, 1, 0, 15);
            wait_tick($sformatf("crit%0d", i));
            check_out($sformatf("crit%0d", i));
        end
        reset_n = 1'b0;
        #1;
        push(0, 0, 0, 0);
        check_out("midreset");
        cmp("midreset.tick", int'(tick), 0);
        @(negedge clk);
        reset_n = 1'b1;
        rel_cyc = cyc;
        push(0, 0, 0, 0);
        check_out("after_release");

        // Health stuck at 15: SICK on the first tick, DEAD ten ticks later
        push(2, 1, 0, 15);
        wait_tick("sick_t1");
        cmp("first_tick_after_midreset", tick_cyc - rel_cyc, 4);
        check_out("sick_t1");
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) push(4, 0, 1, 15);
            else         push(2, 1, 0, 15);
            wait_tick($sformatf("die%0d", i));
            check_out($sformatf("die%0d", i));
        end

        // DEAD ignores stats and wake presses
        set_stats(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            wake = 1'b1;
            @(negedge clk);
            wake = 1'b0;
            push(4, 0, 1, 0);
            wait_tick($sformatf("dead%0d", i));
            check_out($sformatf("dead%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pet_mood.md
PET_MOOD -- requirements
Module: pet_mood

Interface
REQ-001 The module SHALL have parameter TICK_DIV, default 27_000_000, meaning clk cycles per evaluation tick (1 s at 27 MHz).
REQ-002 The module SHALL have parameter SICK_TH, default 12, meaning the health/energy level at or above which SICK/SLEEP is entered.
REQ-003 The module SHALL have parameter NEEDY_TH, default 8, meaning the worst-stat level at or above which NEEDY is entered.
REQ-004 The module SHALL have parameter CRIT_TICKS, default 10, meaning consecutive critical ticks in SICK before DEAD.
REQ-005 The module SHALL have parameter SLEEP_TICKS, default 8, meaning ticks spent in SLEEP before auto-wake.
REQ-006 The module SHALL have ports: clk input 1, 27 MHz system clock; reset_n input 1, asynchronous active-low reset.
REQ-007 The module SHALL have inputs hunger, happiness, health, hygiene, energy, social, each 4 bits, need levels (0 best, 15 worst) from the stats block, same clock domain.
REQ-008 The module SHALL have input wake, 1 bit, a synchronised, debounced button level.
REQ-009 The module SHALL have outputs mood (3 bits, registered state code), alarm (1 bit), dead (1 bit), care_score (7 bits, sum of the six stats) and tick (1 bit, one-cycle tick strobe).

Function
REQ-010 A tick counter SHALL count 0..TICK_DIV-1, assert tick for exactly one cycle on the terminal count, and wrap to 0.
REQ-011 wake SHALL be rising-edge detected into a one-cycle wake_p pulse; a held level SHALL produce one pulse only.
REQ-012 worst SHALL be the maximum of the six stats; care_score SHALL be the zero-extended 7-bit sum (max 90, no overflow), registered on tick only.
REQ-013 States: HAPPY=0, NEEDY=1, SICK=2, SLEEP=3, DEAD=4; mood SHALL equal the current state; codes 5-7 are unreachable and SHALL recover to HAPPY.
REQ-014 In HAPPY or NEEDY, on tick, the next state SHALL be chosen by priority: health>=SICK_TH -> SICK; else energy>=SICK_TH -> SLEEP; else worst>=NEEDY_TH -> NEEDY; else HAPPY.
REQ-015 In SICK, on tick: if health==15, crit_cnt SHALL increment; otherwise crit_cnt SHALL clear.
REQ-016 In SICK, on tick, when crit_cnt reaches CRIT_TICKS the state SHALL go to DEAD; otherwise, if health<SICK_TH, the state SHALL go to NEEDY.
REQ-017 In SLEEP, on tick, sleep_cnt SHALL increment; health>=SICK_TH SHALL take priority and go to SICK; otherwise sleep_cnt reaching SLEEP_TICKS SHALL go to NEEDY.
REQ-018 In SLEEP, wake_p SHALL go to NEEDY on the next clock regardless of tick, unless the same-cycle tick selects SICK.
REQ-019 crit_cnt and sleep_cnt SHALL clear on any exit from their state; each SHALL saturate at its limit and never wrap.
REQ-020 DEAD SHALL be absorbing: only reset_n leaves it, and wake and stats SHALL be ignored.
REQ-021 dead SHALL be high exactly when the state is DEAD.
REQ-022 alarm SHALL be registered and high in SICK, or in NEEDY with worst==15; it SHALL be low in HAPPY, SLEEP and DEAD.
REQ-023 All state transitions SHALL take effect one clk after the qualifying tick or wake_p; output latency SHALL be 1 cycle.

Reset
REQ-024 Assertion of reset_n low SHALL immediately force: state HAPPY, mood=0, alarm=0, dead=0, care_score=0, tick=0, tick counter=0, crit_cnt=0, sleep_cnt=0, edge-detect register=0.
REQ-025 Reset mid-tick-period SHALL restart the full TICK_DIV period after deassertion.
REQ-026 The first tick after reset SHALL occur TICK_DIV cycles after deassertion.

Structure
REQ-027 A shared package pet_pkg SHALL hold the state enum/codes and the default threshold constants, for reuse by the display block.
REQ-028 The tick prescaler SHALL be a sub-module tick_gen (parameter TICK_DIV, ports clk, reset_n, tick).
REQ-029 The FSM, counters, compare/sum logic and output registers SHALL reside in pet_mood.

Verification (bench uses TICK_DIV=4)
REQ-030 All stats 0, run 3 ticks -> mood=0, alarm=0, care_score=0; tick pulses spaced 4 cycles.
REQ-031 hygiene=15, others 0, one tick -> mood=1, alarm=1, care_score=15.
REQ-032 health=15 held -> tick1 mood=2, alarm=1; DEAD after CRIT_TICKS further ticks with dead=1; then stats 0 and wake pulses -> mood stays 4.
REQ-033 energy=13, others 0 -> mood=3; energy=0 and wake rises mid-period -> mood=1 next clk; a held wake gives no second effect; with no wake, mood=1 after 8 ticks.
REQ-034 In SLEEP, wake rising and tick in the same cycle with health=12 -> mood=2.
REQ-035 In SICK with crit_cnt=5, pulse reset_n low for 1 cycle -> all outputs at reset values; the first tick occurs 4 cycles after release.
